cpu_dout_display: RTL and testbench

- Output-side consumer of the CPU's Dout/Dval data port.
- Captures Dout on each rising edge of Dval and converts it to decimal with a sequential double-dabble engine.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display with the result.
- Sits beside the CPU at top level, in the same clock domain as the CPU.

---
 rtl/cpu_dout_display.sv | 196 +++++++++++++++++++
 tb/tb_cpu_dout_display.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dout_display.sv
// rtl/cpu_dout_display.sv - Dout/Dval capture, double-dabble decimal conversion, 4-digit 7-seg scan
// Optional hex display mode: define CPU_DOUT_DISPLAY_HEX_MODE_EN.
module cpu_dout_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Dout,
  input  logic       Dval,
  input  logic       Signed,
`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
  input  logic       HexMode,
`endif
  output logic [6:0] Seg,
  output logic [3:0] Digit,
  output logic [7:0] Value,
  output logic       Busy
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [4:0] SYM_DASH  = 5'd16;
  localparam logic [4:0] SYM_BLANK = 5'd17;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state;
  logic        dval_d;
  logic        rise;
  logic        sgn;
  logic        conv_sgn;
  logic        pending;
  logic        hex_sel;
  logic        hex_req;
  logic        next_hex;
  logic [7:0]  next_val;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic [2:0]  iter;
  logic        disp_sgn;
  logic        disp_hex;
  logic [3:0]  disp_hun;
  logic [3:0]  disp_ten;
  logic [3:0]  disp_one;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  digit_idx;
  logic [4:0]  sym;

`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
  assign hex_sel = HexMode;
`else
  assign hex_sel = 1'b0;
`endif

  assign rise     = Dval & ~dval_d;
  assign next_hex = rise ? hex_sel : hex_req;
  assign next_val = rise ? Dout : Value;

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [4:0] s);
    case (s)
      5'd0:    seg_code = 7'b1000000;
      5'd1:    seg_code = 7'b1111001;
      5'd2:    seg_code = 7'b0100100;
      5'd3:    seg_code = 7'b0110000;
      5'd4:    seg_code = 7'b0011001;
      5'd5:    seg_code = 7'b0010010;
      5'd6:    seg_code = 7'b0000010;
      5'd7:    seg_code = 7'b1111000;
      5'd8:    seg_code = 7'b0000000;
      5'd9:    seg_code = 7'b0010000;
      5'd10:   seg_code = 7'b0001000;
      5'd11:   seg_code = 7'b0000011;
      5'd12:   seg_code = 7'b1000110;
      5'd13:   seg_code = 7'b0100001;
      5'd14:   seg_code = 7'b0000110;
      5'd15:   seg_code = 7'b0001110;
      SYM_DASH: seg_code = 7'b0111111;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      dval_d   <= 1'b0;
      Value    <= 8'd0;
      sgn      <= 1'b0;
      conv_sgn <= 1'b0;
      pending  <= 1'b0;
      hex_req  <= 1'b0;
      mag      <= 8'd0;
      bcd      <= 12'd0;
      iter     <= 3'd0;
      disp_sgn <= 1'b0;
      disp_hex <= 1'b0;
      disp_hun <= 4'd0;
      disp_ten <= 4'd0;
      disp_one <= 4'd0;
      Busy     <= 1'b0;
    end else begin
      dval_d <= Dval;
      Busy   <= (state != IDLE);
      if (rise) begin
        Value   <= Dout;
        sgn     <= Signed & Dout[7];
        hex_req <= hex_sel;
      end
      case (state)
        IDLE: begin
          if (rise) begin
            if (hex_sel) begin
              disp_hex <= 1'b1;
              disp_sgn <= 1'b0;
              disp_hun <= 4'd0;
              disp_ten <= Dout[7:4];
              disp_one <= Dout[3:0];
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          // 8-bit two's-complement negate maps -128 onto 0x80, i.e. magnitude 128
          mag      <= sgn ? (~Value + 8'd1) : Value;
          conv_sgn <= sgn;
          bcd      <= 12'd0;
          iter     <= 3'd0;
          state    <= SHIFT;
          if (rise) pending <= 1'b1;
        end
        SHIFT: begin
          {bcd, mag} <= {dd_adjust(bcd), mag} << 1;
          iter       <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
          if (rise) pending <= 1'b1;
        end
        DONE: begin
          pending <= 1'b0;
          // A rise landing in DONE itself is folded into the pending decision
          if ((pending | rise) && next_hex) begin
            disp_hex <= 1'b1;
            disp_sgn <= 1'b0;
            disp_hun <= 4'd0;
            disp_ten <= next_val[7:4];
            disp_one <= next_val[3:0];
            state    <= IDLE;
          end else begin
            disp_hex <= 1'b0;
            disp_sgn <= conv_sgn;
            disp_hun <= bcd[11:8];
            disp_ten <= bcd[7:4];
            disp_one <= bcd[3:0];
            state    <= (pending | rise) ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sym = SYM_BLANK;
    case (digit_idx)
      2'd0: sym = {1'b0, disp_one};
      2'd1: if (disp_hex || disp_hun != 4'd0 || disp_ten != 4'd0) sym = {1'b0, disp_ten};
      2'd2: if (!disp_hex && disp_hun != 4'd0) sym = {1'b0, disp_hun};
      default: if (disp_sgn) sym = SYM_DASH;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      Seg       <= 7'h7F;
      Digit     <= 4'hF;
    end else begin
      Seg   <= seg_code(sym);
      Digit <= ~(4'b0001 << digit_idx);
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dout_display.sv
// tb/tb_cpu_dout_display.sv - randomized self-checking bench for cpu_dout_display
// Exercises hex mode too when CPU_DOUT_DISPLAY_HEX_MODE_EN is defined.
module tb_cpu_dout_display;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic       Clock;
  logic       Reset;
  logic [7:0] Dout;
  logic       Dval;
  logic       Signed;
`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
  logic       HexMode;
`endif
  logic [6:0] Seg;
  logic [3:0] Digit;
  logic [7:0] Value;
  logic       Busy;

  int tests  = 0;
  int errors = 0;

  cpu_dout_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .Clock(Clock), .Reset(Reset), .Dout(Dout), .Dval(Dval), .Signed(Signed),
`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
    .HexMode(HexMode),
`endif
    .Seg(Seg), .Digit(Digit), .Value(Value), .Busy(Busy));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // Expected {digit3, digit2, digit1, digit0} segment patterns from plain decimal arithmetic
  function automatic logic [27:0] model_dec(input logic [7:0] v, input logic s);
    int n, m, h, t, o;
    logic [6:0] d3, d2, d1, d0;
    n  = (s && v[7]) ? int'(v) - 256 : int'(v);
    m  = (n < 0) ? -n : n;
    h  = m / 100;
    t  = (m / 10) % 10;
    o  = m % 10;
    d3 = (n < 0) ? SEG_DASH : SEG_BLANK;
    d2 = (h != 0) ? SEG_TAB[h] : SEG_BLANK;
    d1 = (h != 0 || t != 0) ? SEG_TAB[t] : SEG_BLANK;
    d0 = SEG_TAB[o];
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [27:0] model_hex(input logic [7:0] v);
    return {SEG_BLANK, SEG_BLANK, SEG_TAB[int'(v) / 16], SEG_TAB[int'(v) % 16]};
  endfunction

  task automatic scan_check(input logic [27:0] exp, input string name);
    int idx;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge Clock);
      case (Digit)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      tests++;
      if (idx < 0) begin
        errors++;
        $display("FAIL %s_digit: Digit=%b is not one-hot-low", name, Digit);
      end else if (Seg !== exp[idx*7 +: 7]) begin
        errors++;
        $display("FAIL %s_seg%0d: got %b expected %b", name, idx, Seg, exp[idx*7 +: 7]);
      end
    end
  endtask

  task automatic convert_and_check(input logic [7:0] v, input logic s, input string name);
    logic exp_busy;
    @(negedge Clock);
    Dout = v; Signed = s; Dval = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Dval = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge Clock);
      exp_busy = (k >= 1 && k <= 10);
      tests++;
      if (Busy !== exp_busy) begin
        errors++;
        $display("FAIL %s_busy_k%0d: got %b expected %b", name, k, Busy, exp_busy);
      end
    end
    tests++;
    if (Value !== v) begin
      errors++;
      $display("FAIL %s_value: got %0d expected %0d", name, Value, v);
    end
    scan_check(model_dec(v, s), name);
  endtask

  task automatic test_reset;
    logic [3:0] exp_d;
    logic [6:0] exp_s;
    Reset = 1'b1; Dval = 1'b0; Dout = 8'd0; Signed = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    tests++;
    if (Seg !== 7'h7F || Digit !== 4'hF || Value !== 8'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Seg=%b Digit=%b Value=%0d Busy=%b expected 1111111 1111 0 0",
               Seg, Digit, Value, Busy);
    end
    Reset = 1'b0;
    for (int k = 0; k < 8 * SCAN_DIV; k++) begin
      @(negedge Clock);
      exp_d = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      exp_s = (exp_d == 4'b1110) ? SEG_TAB[0] : SEG_BLANK;
      tests++;
      if (Digit !== exp_d || Seg !== exp_s) begin
        errors++;
        $display("FAIL reset_scan_k%0d: Digit=%b Seg=%b expected %b %b", k, Digit, Seg, exp_d, exp_s);
      end
    end
  endtask

  task automatic test_decimal;
    logic [7:0] vals [10] = '{8'd123, 8'hFF, 8'h80, 8'h80, 8'd0, 8'hFF, 8'h7F, 8'd100, 8'd10, 8'h81};
    logic       sgns [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) convert_and_check(vals[i], sgns[i], $sformatf("dec%0d", i));
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++)
      convert_and_check(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
  endtask

  task automatic test_dval_held;
    int busy_cycles = 0;
    @(negedge Clock);
    Dout = 8'd7; Signed = 1'b0; Dval = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clock);
      if (Busy === 1'b1) busy_cycles++;
    end
    Dval = 1'b0;
    tests++;
    if (busy_cycles != 10) begin
      errors++;
      $display("FAIL held_busy_cycles: got %0d expected 10", busy_cycles);
    end
    scan_check(model_dec(8'd7, 1'b0), "held");
  endtask

  task automatic test_back_to_back;
    logic [3:0] prev;
    logic       found = 1'b0;
    logic       exp_busy;
    int         seen6 = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = Digit;
      @(negedge Clock);
      if (Digit == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    tests++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_align: Digit=%b never entered 1110", Digit);
    end
    // Rise at N lands 5 edges after the ones digit started, so N+11..N+14 scan the ones digit
    for (int k = -4; k <= 24; k++) begin
      Dval = (k == 0 || k == 3 || k == 5);
      Dout = (k == 0) ? 8'd5 : (k == 3) ? 8'd6 : 8'd9;
      Signed = 1'b0;
      @(negedge Clock);
      if (k >= 0) begin
        exp_busy = (k >= 1 && k <= 20);
        tests++;
        if (Busy !== exp_busy) begin
          errors++;
          $display("FAIL b2b_busy_k%0d: got %b expected %b", k, Busy, exp_busy);
        end
        if (Digit == 4'b1110 && Seg == SEG_TAB[6]) seen6++;
        if (k >= 11 && k <= 14) begin
          tests++;
          if (Digit !== 4'b1110 || Seg !== SEG_TAB[5]) begin
            errors++;
            $display("FAIL b2b_first_k%0d: Digit=%b Seg=%b expected 1110 %b", k, Digit, Seg, SEG_TAB[5]);
          end
        end
      end
    end
    Dval = 1'b0;
    tests++;
    if (seen6 != 0) begin
      errors++;
      $display("FAIL b2b_dropped: value 6 displayed %0d times expected 0", seen6);
    end
    tests++;
    if (Value !== 8'd9) begin
      errors++;
      $display("FAIL b2b_value: got %0d expected 9", Value);
    end
    scan_check(model_dec(8'd9, 1'b0), "b2b");
  endtask

  task automatic test_reset_mid;
    @(negedge Clock);
    Dout = 8'd200; Signed = 1'b0; Dval = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Dval = 1'b0;
    repeat (4) @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    tests++;
    if (Busy !== 1'b0 || Seg !== 7'h7F || Digit !== 4'hF || Value !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs: Busy=%b Seg=%b Digit=%b Value=%0d expected 0 1111111 1111 0",
               Busy, Seg, Digit, Value);
    end
    @(negedge Clock);
    Reset = 1'b0;
    scan_check(model_dec(8'd0, 1'b0), "midreset");
  endtask

`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
  task automatic test_hex;
    @(negedge Clock);
    HexMode = 1'b1; Dout = 8'hA5; Signed = 1'b1; Dval = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Dval = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge Clock);
      tests++;
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL hex_busy_k%0d: got %b expected 0", k, Busy);
      end
    end
    scan_check(model_hex(8'hA5), "hex");
    HexMode = 1'b0;
  endtask
`endif

  initial begin
`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
    HexMode = 1'b0;
`endif
    test_reset();
    test_decimal();
    test_random();
    test_dval_held();
    test_back_to_back();
    test_reset_mid();
`ifdef CPU_DOUT_DISPLAY_HEX_MODE_EN
    test_hex();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
